// File: rtl/pwm_fade_ctrl.sv
// Eight-channel PWM duty fade controller: accepts per-channel targets, ramps each
// channel one step per fade tick (or jumps when forced) and loads duties round-robin.
module pwm_fade_ctrl #(
  parameter int STEP_DIV = 100,
  parameter int MAX_DUTY = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_chan,
  input  logic [6:0] req_target,
  input  logic       req_enable,
  input  logic       req_immediate,
  output logic [6:0] duty_in,
  output logic [2:0] channel_sel,
  output logic       load_duty,
  output logic [7:0] enable_pwm,
  output logic [7:0] busy
);

  localparam logic [0:0]  ST_IDLE   = 1'b0;
  localparam logic [0:0]  ST_LOAD   = 1'b1;
  localparam logic [15:0] TICK_LAST = 16'(STEP_DIV - 1);
  localparam logic [6:0]  DUTY_CEIL = 7'(MAX_DUTY);

  logic [6:0]  cur_r [8];
  logic [6:0]  tgt_r [8];
  logic [7:0]  en_r;
  logic [7:0]  pend_r;
  logic [7:0]  frc_r;
  logic [2:0]  ptr_r;
  logic [15:0] tick_r;
  logic [0:0]  state_r;
  logic [6:0]  duty_r;
  logic [2:0]  chan_r;
  logic        load_r;

  logic        tick_hit_s;
  logic [7:0]  eligible_s;
  logic        found_s;
  logic        do_grant_s;
  logic [2:0]  grant_idx_s;
  logic [2:0]  scan_s;
  logic [6:0]  next_cur_s;
  logic [6:0]  req_tgt_s;
  logic [7:0]  grant_mask_s;
  logic [7:0]  force_mask_s;
  logic [7:0]  pend_next_s;
  logic [7:0]  frc_next_s;

  assign req_ready   = ~rst;
  assign duty_in     = duty_r;
  assign channel_sel = chan_r;
  assign load_duty   = load_r;
  assign enable_pwm  = en_r;

  assign tick_hit_s  = (tick_r == TICK_LAST);
  assign eligible_s  = pend_r | frc_r;
  assign do_grant_s  = found_s && (state_r == ST_IDLE);
  assign req_tgt_s   = (req_target > DUTY_CEIL) ? DUTY_CEIL : req_target;

  // Per-channel "not yet at target" flags.
  always_comb begin
    busy = 8'h00;
    for (int i = 0; i < 8; i++) begin
      busy[i] = (cur_r[i] != tgt_r[i]);
    end
  end

  // Round-robin search for the first eligible channel starting at ptr.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = 3'd0;
    scan_s      = 3'd0;
    for (int k = 0; k < 8; k++) begin
      scan_s = ptr_r + 3'(k);
      if (!found_s && eligible_s[scan_s]) begin
        found_s     = 1'b1;
        grant_idx_s = scan_s;
      end else begin
        found_s     = found_s;
        grant_idx_s = grant_idx_s;
      end
    end
  end

  // Duty value the granted channel moves to: forced jump, or one step toward target.
  always_comb begin
    next_cur_s = cur_r[grant_idx_s];
    if (frc_r[grant_idx_s]) begin
      next_cur_s = tgt_r[grant_idx_s];
    end else if (cur_r[grant_idx_s] < tgt_r[grant_idx_s]) begin
      next_cur_s = cur_r[grant_idx_s] + 7'd1;
    end else if (cur_r[grant_idx_s] > tgt_r[grant_idx_s]) begin
      next_cur_s = cur_r[grant_idx_s] - 7'd1;
    end else begin
      next_cur_s = cur_r[grant_idx_s];
    end
  end

  // Grant clears win over a same-edge tick so a pending step is never queued twice;
  // a same-edge immediate request re-arms force after the grant consumed the old one.
  always_comb begin
    grant_mask_s = do_grant_s ? (8'b1 << grant_idx_s) : 8'h00;
    force_mask_s = (req_valid && req_immediate) ? (8'b1 << req_chan) : 8'h00;
    pend_next_s  = (tick_hit_s ? (pend_r | busy) : pend_r) & ~grant_mask_s;
    frc_next_s   = (frc_r & ~grant_mask_s) | force_mask_s;
  end

  // Fade tick divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_r <= 16'd0;
    end else if (tick_hit_s) begin
      tick_r <= 16'd0;
    end else begin
      tick_r <= tick_r + 16'd1;
    end
  end

  // Per-channel duty, target, enable and request-flag state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        cur_r[i] <= 7'd0;
        tgt_r[i] <= 7'd0;
      end
      en_r   <= 8'h00;
      pend_r <= 8'h00;
      frc_r  <= 8'h00;
      ptr_r  <= 3'd0;
    end else begin
      pend_r <= pend_next_s;
      frc_r  <= frc_next_s;
      if (do_grant_s) begin
        cur_r[grant_idx_s] <= next_cur_s;
        ptr_r              <= grant_idx_s + 3'd1;
      end
      if (req_valid) begin
        tgt_r[req_chan] <= req_tgt_s;
        en_r[req_chan]  <= req_enable;
      end
    end
  end

  // Load sequencer: one strobe per grant, then a mandatory LOAD cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      duty_r  <= 7'd0;
      chan_r  <= 3'd0;
      load_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (do_grant_s) begin
            duty_r  <= next_cur_s;
            chan_r  <= grant_idx_s;
            load_r  <= 1'b1;
            state_r <= ST_LOAD;
          end else begin
            load_r  <= 1'b0;
          end
        end
        ST_LOAD: begin
          load_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          load_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl: directed scenarios plus random traffic,
// all compared every cycle against an arithmetic reference of the fade rules.
module tb_pwm_fade_ctrl;

  localparam int SD = 16;
  localparam int MD = 99;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_chan = 3'd0;
  logic [6:0] req_target = 7'd0;
  logic       req_enable = 1'b0;
  logic       req_immediate = 1'b0;
  logic [6:0] duty_in;
  logic [2:0] channel_sel;
  logic       load_duty;
  logic [7:0] enable_pwm;
  logic [7:0] busy;

  pwm_fade_ctrl #(.STEP_DIV(SD), .MAX_DUTY(MD)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_chan(req_chan), .req_target(req_target), .req_enable(req_enable),
    .req_immediate(req_immediate), .duty_in(duty_in), .channel_sel(channel_sel),
    .load_duty(load_duty), .enable_pwm(enable_pwm), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference state: the channel rules expressed with plain integers.
  int m_cur[8], m_tgt[8];
  bit m_en[8], m_pend[8], m_frc[8];
  int m_ptr, m_tick, m_duty, m_chan;
  bit m_loading, m_load;

  typedef struct { int chan; int duty; int at; } load_t;
  load_t loads_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int load_chan(input int idx);
    return (idx < loads_q.size()) ? loads_q[idx].chan : -1;
  endfunction

  function automatic int load_duty_at(input int idx);
    return (idx < loads_q.size()) ? loads_q[idx].duty : -1;
  endfunction

  function automatic int load_cyc(input int idx);
    return (idx < loads_q.size()) ? loads_q[idx].at : -1000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_cur[i] = 0; m_tgt[i] = 0; m_en[i] = 0; m_pend[i] = 0; m_frc[i] = 0;
    end
    m_ptr = 0; m_tick = 0; m_duty = 0; m_chan = 0; m_loading = 0; m_load = 0;
  endtask

  task automatic model_edge(input bit v, input int c, input int t, input bit e, input bit im);
    bit tick_hit, granted;
    int g, ch, nv;
    tick_hit = (m_tick == SD - 1);
    m_tick   = tick_hit ? 0 : m_tick + 1;
    granted  = 0;
    g        = 0;
    if (!m_loading) begin
      for (int k = 0; k < 8; k++) begin
        ch = (m_ptr + k) % 8;
        if (!granted && (m_pend[ch] || m_frc[ch])) begin
          granted = 1;
          g = ch;
        end
      end
    end
    if (tick_hit) begin
      for (int i = 0; i < 8; i++) if (m_cur[i] != m_tgt[i]) m_pend[i] = 1;
    end
    if (granted) begin
      if (m_frc[g]) nv = m_tgt[g];
      else if (m_tgt[g] > m_cur[g]) nv = m_cur[g] + 1;
      else if (m_tgt[g] < m_cur[g]) nv = m_cur[g] - 1;
      else nv = m_cur[g];
      m_cur[g] = nv; m_pend[g] = 0; m_frc[g] = 0;
      m_ptr = (g + 1) % 8; m_duty = nv; m_chan = g;
    end
    m_load = granted;
    m_loading = granted;
    if (v) begin
      m_tgt[c] = (t > MD) ? MD : t;
      m_en[c]  = e;
      if (im) m_frc[c] = 1;
    end
  endtask

  task automatic check_outputs();
    logic [7:0] exp_en, exp_busy;
    for (int i = 0; i < 8; i++) begin
      exp_en[i]   = m_en[i];
      exp_busy[i] = (m_cur[i] != m_tgt[i]);
    end
    chk("duty_in", duty_in, m_duty);
    chk("channel_sel", channel_sel, m_chan);
    chk("load_duty", load_duty, m_load);
    chk("enable_pwm", enable_pwm, exp_en);
    chk("busy", busy, exp_busy);
    chk("req_ready", req_ready, 1);
  endtask

  task automatic cycle(input bit v, input int c, input int t, input bit e, input bit im);
    req_valid = v; req_chan = 3'(c); req_target = 7'(t);
    req_enable = e; req_immediate = im;
    @(posedge clk);
    cyc++;
    model_edge(v, c, t, e, im);
    #1;
    req_valid = 1'b0;
    if (load_duty === 1'b1) loads_q.push_back('{int'(channel_sel), int'(duty_in), cyc});
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_duty"}, duty_in, 0);
    chk({tag, "_chan"}, channel_sel, 0);
    chk({tag, "_load"}, load_duty, 0);
    chk({tag, "_en"}, enable_pwm, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, req_ready, 0);
  endtask

  initial begin
    int req_cyc;
    model_reset();
    // Reset state.
    @(posedge clk); @(posedge clk); #1;
    check_all_zero("reset");
    rst = 1'b0;
    model_reset();

    // Ramp up ch0 to 3.
    loads_q.delete();
    cycle(1, 0, 3, 1, 0);
    for (int i = 0; i < 80 && loads_q.size() < 3; i++) idle(1);
    chk("up_n", loads_q.size(), 3);
    chk("up0_chan", load_chan(0), 0);
    chk("up0_duty", load_duty_at(0), 1);
    chk("up1_duty", load_duty_at(1), 2);
    chk("up2_duty", load_duty_at(2), 3);
    chk("up_gap1", load_cyc(1) - load_cyc(0), SD);
    chk("up_gap2", load_cyc(2) - load_cyc(1), SD);
    chk("up_busy0", busy[0], 0);
    chk("up_en", enable_pwm, 8'h01);
    idle(20);
    chk("up_no_more", loads_q.size(), 3);

    // Ramp down ch0 from 3 to 1.
    loads_q.delete();
    cycle(1, 0, 1, 1, 0);
    for (int i = 0; i < 60 && loads_q.size() < 2; i++) idle(1);
    chk("dn0_duty", load_duty_at(0), 2);
    chk("dn1_duty", load_duty_at(1), 1);
    chk("dn_gap", load_cyc(1) - load_cyc(0), SD);
    idle(40);
    chk("dn_n", loads_q.size(), 2);

    // Clamp and immediate on ch7 (also leaves ptr at 0).
    loads_q.delete();
    cycle(1, 7, 120, 0, 1);
    req_cyc = cyc;
    idle(2);
    chk("clamp_n", loads_q.size(), 1);
    chk("clamp_chan", load_chan(0), 7);
    chk("clamp_duty", load_duty_at(0), 99);
    chk("clamp_lat", (load_cyc(0) - req_cyc) <= 2, 1);
    idle(40);
    chk("clamp_single", loads_q.size(), 1);

    // Round robin: ch5 requested before ch2, both pending on the same tick.
    for (int i = 0; i < 20 && m_tick != 2; i++) idle(1);
    loads_q.delete();
    cycle(1, 5, 5, 1, 0);
    cycle(1, 2, 5, 1, 0);
    for (int i = 0; i < 40 && loads_q.size() < 2; i++) idle(1);
    chk("rr0_chan", load_chan(0), 2);
    chk("rr0_duty", load_duty_at(0), 1);
    chk("rr1_chan", load_chan(1), 5);
    chk("rr1_duty", load_duty_at(1), 1);
    chk("rr_gap", load_cyc(1) - load_cyc(0), 2);
    idle(100);

    // Collision: new target for ch3 on the edge of its grant.
    cycle(1, 3, 4, 1, 0);
    for (int i = 0; i < 40 && !(m_pend[3] && !m_loading); i++) idle(1);
    loads_q.delete();
    cycle(1, 3, 0, 1, 0);
    chk("col_n", loads_q.size(), 1);
    chk("col_chan", load_chan(0), 3);
    chk("col_old_tgt", load_duty_at(0), 1);
    chk("col_busy", busy[3], 1);
    idle(20);
    chk("col_new_tgt", load_duty_at(1), 0);
    chk("col_gap", load_cyc(1) - load_cyc(0), SD);
    chk("col_done", busy[3], 0);

    // Reset while ch1 is ramping, right after a load strobe.
    cycle(1, 1, 50, 1, 0);
    for (int i = 0; i < 60 && !(m_load && m_chan == 1); i++) idle(1);
    chk("mid_in_load", load_duty, 1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    loads_q.delete();
    idle(60);
    chk("midrst_no_load", loads_q.size(), 0);

    // Random traffic against the reference.
    for (int n = 0; n < 800; n++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom_range(0, 127),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
    end
    idle(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_fade_ctrl.md
PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 Parameter STEP_DIV, default 100, clocks per fade tick; legal range 16..65535.
REQ-002 Parameter MAX_DUTY, default 99, ceiling for any duty value.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  configuration request strobe.
REQ-006 req_ready  output  1  controller accepts a request this cycle.
REQ-007 req_chan  input  3  target channel 0..7.
REQ-008 req_target  input  7  requested duty target.
REQ-009 req_enable  input  1  enable value for the channel.
REQ-010 req_immediate  input  1  1 = jump straight to target; 0 = ramp.
REQ-011 duty_in  output  7  duty value presented to the PWM generator.
REQ-012 channel_sel  output  3  channel being loaded.
REQ-013 load_duty  output  1  one-cycle load strobe.
REQ-014 enable_pwm  output  8  per-channel PWM enable.
REQ-015 busy  output  8  bit i = channel i current duty != target.

Function
REQ-016 The block SHALL keep per-channel registers cur[i], tgt[i], en[i], pend[i], frc[i], a round-robin pointer ptr (3 bits), a tick counter, and an FSM with states IDLE and LOAD.
REQ-017 req_ready SHALL be 1 whenever rst is low; a request is accepted on any edge where req_valid=1.
REQ-018 On acceptance: tgt[req_chan] <= min(req_target, MAX_DUTY); en[req_chan] <= req_enable; if req_immediate=1, frc[req_chan] <= 1.
REQ-019 enable_pwm SHALL equal en[], registered, so it changes on the edge after acceptance; disabling a channel SHALL NOT stop its fade.
REQ-020 The tick counter SHALL count 0..STEP_DIV-1 and wrap; on the edge where it equals STEP_DIV-1, pend[i] <= pend[i] | (cur[i] != tgt[i]) for all i.
REQ-021 Channel i is eligible when pend[i] or frc[i] is set.
REQ-022 IDLE: if any channel is eligible, grant g = first eligible index scanning ptr, ptr+1, ... wrapping modulo 8; on that edge the block SHALL update cur[g] to its new value, drive duty_in <= new cur[g], channel_sel <= g, load_duty <= 1, clear pend[g] and frc[g], set ptr <= g+1 mod 8, and enter LOAD.
REQ-023 New cur[g] SHALL be: if frc[g], tgt[g]; else cur[g]+1 if cur[g] < tgt[g]; cur[g]-1 if cur[g] > tgt[g]; cur[g] if equal.
REQ-024 LOAD: load_duty <= 0, return to IDLE; duty_in and channel_sel hold their last values.
REQ-025 load_duty SHALL be high for exactly one cycle per grant, with at most one grant every 2 cycles.
REQ-026 A request accepted on the same edge as a grant to that channel: the grant uses pre-request tgt/frc; the new target and force take effect from the following cycle.
REQ-027 A tick while pend[i] is still set SHALL NOT queue a second step; a channel moves at most one step per tick unless forced.
REQ-028 busy[i] SHALL be combinational (cur[i] != tgt[i]).
REQ-029 All arithmetic SHALL be 7-bit unsigned; cur never leaves 0..MAX_DUTY.

Reset
REQ-030 While rst is high: cur, tgt, en, pend, frc, ptr, and tick counter = 0; FSM = IDLE; duty_in = 0, channel_sel = 0, load_duty = 0, enable_pwm = 8'h00, busy = 8'h00, req_ready = 0.
REQ-031 rst asserted mid-fade or mid-LOAD SHALL abort immediately; there SHALL be no load strobe until a new eligible event occurs after release.

Verification
REQ-032 Ramp up: STEP_DIV=16, request ch0 target 3 ramp enable=1 -> loads (ch0,1), (ch0,2), (ch0,3) on three consecutive ticks; busy[0] then 0; enable_pwm = 8'h01.
REQ-033 Ramp down: ch0 at 3, request target 1 -> loads 2, then 1, one tick apart; no further loads.
REQ-034 Round robin: ptr=0, ch2 and ch5 both pending at one tick -> load (ch2) then (ch5) two cycles later; ptr ends at 6.
REQ-035 Clamp and immediate: request ch7 target 120, immediate=1 -> a single load (ch7,99) within 2 cycles, with no waiting for a tick.
REQ-036 Collision: request to ch3 on the same edge as its grant -> the step uses the old target; the new target applies from the next tick.
REQ-037 Reset mid-fade: assert rst while ch1 is ramping -> all outputs 0 immediately; no load_duty after release without a new request.
